// File: rtl/snes_pad_pkg.sv
// Shared definitions for the serial game-pad poller: FSM encoding, default frame
// length and the bit-index width helper.
package snes_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } pad_state_e;

  localparam int NUM_BITS_DEF = 16;

  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  localparam int BIT_IDX_W_DEF = idx_width(NUM_BITS_DEF);

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
module pad_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/snes_pad_poller.sv
// Serial game-pad poller: generates latch and shift clock, samples the pad data
// and publishes a registered button word with valid/changed strobes.
module snes_pad_poller
  import snes_pad_pkg::*;
#(
  parameter int LATCH_CYCLES       = 1200,
  parameter int HALF_BIT_CYCLES    = 600,
  parameter int POLL_PERIOD_CYCLES = 1666667,
  parameter int NUM_BITS           = NUM_BITS_DEF
) (
  input  logic                PCLK,
  input  logic                PRESERN,
  input  logic                poll_req,
  input  logic                auto_en,
  input  logic                contRead,
  output logic                contWrite,
  output logic                contCLK,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  output logic                buttons_changed,
  output logic                busy
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int AUTO_W  = $clog2(POLL_PERIOD_CYCLES + 1);
  localparam int IDX_W   = idx_width(NUM_BITS);

  logic rd_sync_s;
  logic auto_expire_s;
  logic trigger_s;

  pad_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_q, bit_d;
  logic                phase_hi_q, phase_hi_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                pending_q, pending_d;
  logic [AUTO_W-1:0]   auto_q, auto_d;
  logic                cont_write_q, cont_write_d;
  logic                cont_clk_q, cont_clk_d;
  logic [NUM_BITS-1:0] buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic                changed_q, changed_d;
  logic                busy_q, busy_d;

  // Idle level of the pad line is high (not pressed).
  pad_sync #(.RESET_VAL(1'b1)) u_rd_sync (
    .clk   (PCLK),
    .rst_n (PRESERN),
    .d     (contRead),
    .q     (rd_sync_s)
  );

  always_comb begin
    auto_expire_s = auto_en && (auto_q == AUTO_W'(POLL_PERIOD_CYCLES - 1));
    trigger_s     = poll_req || auto_expire_s;
    if (!auto_en) begin
      auto_d = '0;
    end else if (auto_expire_s) begin
      auto_d = '0;
    end else begin
      auto_d = auto_q + AUTO_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    phase_hi_d   = phase_hi_q;
    shift_d      = shift_q;
    pending_d    = pending_q;
    cont_write_d = cont_write_q;
    cont_clk_d   = cont_clk_q;
    buttons_d    = buttons_q;
    valid_d      = 1'b0;
    changed_d    = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger_s || pending_q) begin
          state_d      = ST_LATCH;
          cnt_d        = '0;
          pending_d    = 1'b0;
          cont_write_d = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LATCH: begin
        if (trigger_s) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
        if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
          state_d      = ST_SHIFT;
          cnt_d        = '0;
          bit_d        = '0;
          phase_hi_d   = 1'b0;
          cont_write_d = 1'b0;
          cont_clk_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (trigger_s) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
        if (cnt_q != CNT_W'(HALF_BIT_CYCLES - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!phase_hi_q) begin
          // Last low-phase cycle: the pad line is inverted so 1 means pressed.
          cnt_d           = '0;
          shift_d[bit_q]  = ~rd_sync_s;
          phase_hi_d      = 1'b1;
          cont_clk_d      = 1'b1;
        end else if (bit_q == IDX_W'(NUM_BITS - 1)) begin
          cnt_d     = '0;
          state_d   = ST_DONE;
          buttons_d = shift_q;
          valid_d   = 1'b1;
          changed_d = (shift_q != buttons_q);
          busy_d    = 1'b0;
        end else begin
          cnt_d      = '0;
          bit_d      = bit_q + IDX_W'(1);
          phase_hi_d = 1'b0;
          cont_clk_d = 1'b0;
        end
      end

      ST_DONE: begin
        // A trigger landing here is kept for the following IDLE cycle.
        pending_d = trigger_s;
        if (pending_q) begin
          state_d      = ST_LATCH;
          cnt_d        = '0;
          cont_write_d = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pending_d    = 1'b0;
        cont_write_d = 1'b0;
        cont_clk_d   = 1'b1;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      phase_hi_q   <= 1'b0;
      shift_q      <= '0;
      pending_q    <= 1'b0;
      auto_q       <= '0;
      cont_write_q <= 1'b0;
      cont_clk_q   <= 1'b1;
      buttons_q    <= '0;
      valid_q      <= 1'b0;
      changed_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      phase_hi_q   <= phase_hi_d;
      shift_q      <= shift_d;
      pending_q    <= pending_d;
      auto_q       <= auto_d;
      cont_write_q <= cont_write_d;
      cont_clk_q   <= cont_clk_d;
      buttons_q    <= buttons_d;
      valid_q      <= valid_d;
      changed_q    <= changed_d;
      busy_q       <= busy_d;
    end
  end

  assign contWrite       = cont_write_q;
  assign contCLK         = cont_clk_q;
  assign buttons         = buttons_q;
  assign buttons_valid   = valid_q;
  assign buttons_changed = changed_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_snes_pad_poller.sv
// Randomised and directed bench for snes_pad_poller against a frame-offset
// reference model driven by a behavioural game-pad.
module tb_snes_pad_poller;

  localparam int L  = 8;
  localparam int H  = 4;
  localparam int P  = 400;
  localparam int NB = 16;
  localparam int D  = L + 2 * NB * H;

  logic          PCLK = 1'b0;
  logic          PRESERN = 1'b0;
  logic          poll_req = 1'b0;
  logic          auto_en = 1'b0;
  logic          contRead = 1'b1;
  logic          contWrite;
  logic          contCLK;
  logic [NB-1:0] buttons;
  logic          buttons_valid;
  logic          buttons_changed;
  logic          busy;

  snes_pad_poller #(
    .LATCH_CYCLES       (L),
    .HALF_BIT_CYCLES    (H),
    .POLL_PERIOD_CYCLES (P),
    .NUM_BITS           (NB)
  ) dut (
    .PCLK            (PCLK),
    .PRESERN         (PRESERN),
    .poll_req        (poll_req),
    .auto_en         (auto_en),
    .contRead        (contRead),
    .contWrite       (contWrite),
    .contCLK         (contCLK),
    .buttons         (buttons),
    .buttons_valid   (buttons_valid),
    .buttons_changed (buttons_changed),
    .busy            (busy)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int tb_edge = -1;

  // pad model
  logic [NB-1:0] pad_raw  = '1;
  logic [NB-1:0] pad_next = '1;
  int            pad_idx  = NB;
  logic          prev_clk = 1'b1;
  logic          prev_cw  = 1'b0;
  int            frame_cnt = 0;
  int            valid_cnt = 0;
  int            last_rise = 0;

  // reference model
  bit            m_in_frame;
  bit            m_pend;
  int            m_start;
  int            m_auto;
  logic [NB-1:0] m_shift;
  logic [NB-1:0] m_buttons;
  bit            m_valid;
  bit            m_changed;
  logic          m_rd1;
  logic          m_rd2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, tb_edge, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_pend     = 1'b0;
    m_start    = 0;
    m_auto     = 0;
    m_shift    = '0;
    m_buttons  = '0;
    m_valid    = 1'b0;
    m_changed  = 1'b0;
    m_rd1      = 1'b1;
    m_rd2      = 1'b1;
  endtask

  task automatic model_edge();
    logic syncv;
    bit   expire;
    bit   trig;
    int   off;
    if (!PRESERN) begin
      model_reset();
      return;
    end
    syncv = m_rd2;
    m_rd2 = m_rd1;
    m_rd1 = contRead;
    expire = auto_en && (m_auto == P - 1);
    if (!auto_en || expire) m_auto = 0;
    else m_auto++;
    trig = poll_req || expire;
    m_valid   = 1'b0;
    m_changed = 1'b0;
    if (m_in_frame) begin
      off = tb_edge - m_start;
      if (off == D + 1) begin
        if (m_pend) begin
          m_start = tb_edge;
          m_pend  = trig;
        end else begin
          m_in_frame = 1'b0;
          m_pend     = trig;
        end
      end else begin
        if (trig) m_pend = 1'b1;
        if (off >= L && off < D && ((off - L) % (2 * H)) == H)
          m_shift[(off - L) / (2 * H)] = ~syncv;
        if (off == D) begin
          m_changed = (m_shift != m_buttons);
          m_buttons = m_shift;
          m_valid   = 1'b1;
        end
      end
    end else if (trig || m_pend) begin
      m_in_frame = 1'b1;
      m_start    = tb_edge;
      m_pend     = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic e_cw, e_clk, e_busy;
    int   off;
    e_cw = 1'b0; e_clk = 1'b1; e_busy = 1'b0;
    if (m_in_frame) begin
      off = tb_edge - m_start;
      if (off < L) begin
        e_cw = 1'b1; e_busy = 1'b1;
      end else if (off < D) begin
        e_clk  = (((off - L) / H) % 2) == 1;
        e_busy = 1'b1;
      end
    end
    check_eq("contWrite", {31'd0, contWrite}, {31'd0, e_cw});
    check_eq("contCLK", {31'd0, contCLK}, {31'd0, e_clk});
    check_eq("busy", {31'd0, busy}, {31'd0, e_busy});
    check_eq("buttons_valid", {31'd0, buttons_valid}, {31'd0, m_valid});
    check_eq("buttons_changed", {31'd0, buttons_changed}, {31'd0, m_changed});
    check_eq("buttons", {16'd0, buttons}, {16'd0, m_buttons});
  endtask

  task automatic pad_update();
    if (buttons_valid) valid_cnt++;
    if (contWrite && !prev_cw) begin
      pad_raw = pad_next;
      frame_cnt++;
      last_rise = tb_edge;
    end
    if (contWrite) pad_idx = 0;
    else if (contCLK && !prev_clk) pad_idx++;
    prev_cw  = contWrite;
    prev_clk = contCLK;
    contRead = (pad_idx < NB) ? pad_raw[pad_idx] : 1'b1;
  endtask

  task automatic tick(input bit poll);
    poll_req = poll;
    @(posedge PCLK);
    tb_edge++;
    model_edge();
    #1;
    check_outputs();
    pad_update();
    poll_req = 1'b0;
  endtask

  task automatic run_until_valid(input int budget);
    int n;
    n = 0;
    while (!buttons_valid && n < budget) begin
      tick(1'b0);
      n++;
    end
    if (!buttons_valid) check_eq("valid_timeout", {31'd0, buttons_valid}, 32'd1);
  endtask

  int base;
  int f0;
  int v0;

  initial begin
    model_reset();
    repeat (3) tick(1'b0);
    PRESERN = 1'b1;
    repeat (4) tick(1'b0);

    // single frame, bit0 pressed
    pad_next = 16'hFFFE;
    tick(1'b1);
    base = tb_edge;
    run_until_valid(300);
    check_eq("frame_len", tb_edge - base, D);
    check_eq("first_word", {16'd0, buttons}, 32'h0000_0001);
    check_eq("first_changed", {31'd0, buttons_changed}, 32'd1);
    check_eq("first_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick(1'b0);

    // same pattern again: valid but not changed
    tick(1'b1);
    run_until_valid(300);
    check_eq("repeat_changed", {31'd0, buttons_changed}, 32'd0);
    repeat (5) tick(1'b0);

    // pending request serviced, third request dropped
    f0 = frame_cnt;
    tick(1'b1);
    base = tb_edge;
    repeat (49) tick(1'b0);
    tick(1'b1);
    repeat (9) tick(1'b0);
    tick(1'b1);
    run_until_valid(300);
    tick(1'b0);
    check_eq("pending_rise", last_rise - base, D + 1);
    run_until_valid(300);
    repeat (30) tick(1'b0);
    check_eq("two_frames", frame_cnt - f0, 2);

    // auto poll
    pad_next = 16'h1234;
    v0 = valid_cnt;
    auto_en = 1'b1;
    repeat (1200) tick(1'b0);
    auto_en = 1'b0;
    repeat (300) tick(1'b0);
    check_eq("auto_frames", valid_cnt - v0, 3);
    repeat (500) tick(1'b0);
    check_eq("auto_off", valid_cnt - v0, 3);

    // reset mid-shift
    pad_next = 16'h0F0F;
    tick(1'b1);
    repeat (70) tick(1'b0);
    PRESERN = 1'b0;
    #1;
    model_reset();
    v0 = valid_cnt;
    check_outputs();
    repeat (3) tick(1'b0);
    PRESERN = 1'b1;
    repeat (200) tick(1'b0);
    check_eq("reset_no_valid", valid_cnt - v0, 0);
    check_eq("reset_buttons", {16'd0, buttons}, 32'd0);
    tick(1'b1);
    run_until_valid(300);
    check_eq("after_reset_word", {16'd0, buttons}, 32'h0000_F0F0);
    repeat (5) tick(1'b0);

    // alternating pattern: bit order and sample point
    pad_next = 16'h5555;
    tick(1'b1);
    run_until_valid(300);
    check_eq("alt_word", {16'd0, buttons}, 32'h0000_AAAA);
    repeat (5) tick(1'b0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) auto_en = ~auto_en;
      if (!contWrite) pad_next = 16'($urandom);
      tick($urandom_range(0, 119) == 0);
    end
    auto_en = 1'b0;
    repeat (400) tick(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snes_pad_poller.md
Name: snes_pad_poller

Overview:
- Sequences the serial game-pad port: generates the latch pulse (contWrite) and the 16-pulse shift clock (contCLK) directly from PCLK-derived timing, and samples contRead.
- Delivers a registered 16-bit button word with a one-cycle valid strobe.
- Polls on software request or on a free-running auto-poll timer.
- Sits between the pad pins and the APB register block.

Parameters:
- LATCH_CYCLES, 1200: contWrite high time in PCLK cycles (12 us at 100 MHz).
- HALF_BIT_CYCLES, 600: contCLK low time, and also high time, per bit in PCLK cycles (6 us). Must be >= 3.
- POLL_PERIOD_CYCLES, 1666667: auto-poll interval in PCLK cycles (60 Hz).
- NUM_BITS, 16: bits shifted per frame.

Ports:
- PCLK  in  1  system clock
- PRESERN  in  1  asynchronous active-low reset
- poll_req  in  1  single-cycle request for one frame
- auto_en  in  1  enables periodic auto-poll
- contRead  in  1  pad serial data, asynchronous; 0 = pressed
- contWrite  out  1  pad latch
- contCLK  out  1  pad shift clock, idles high
- buttons  out  NUM_BITS  last captured word; 1 = pressed; bit0 = first bit shifted
- buttons_valid  out  1  one-cycle strobe when buttons updates
- buttons_changed  out  1  one-cycle strobe with buttons_valid if the new word differs from the previous one
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset values: contWrite=0, contCLK=1, buttons=0, buttons_valid=0, buttons_changed=0, busy=0, state IDLE, pending=0, auto timer=0.
- contRead passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Trigger: poll_req=1, or auto timer expiry while auto_en=1.
  - Auto timer counts 0..POLL_PERIOD_CYCLES-1 while auto_en=1, then wraps; expiry is the wrap cycle.
  - auto_en=0 holds the timer at 0.
- States:
  - IDLE: on a trigger sampled at edge N, go to LATCH at edge N. From edge N: contWrite=1 and busy=1.
  - LATCH: contWrite=1 for exactly LATCH_CYCLES cycles. At edge N+LATCH_CYCLES, contWrite=0; go to SHIFT with bit index 0.
  - SHIFT: each bit is a low phase (contCLK=0) for HALF_BIT_CYCLES, then a high phase (contCLK=1) for HALF_BIT_CYCLES.
    - Sample the synchronised contRead in the last cycle of the low phase; store its inverse into shift bit[index].
    - After the high phase of bit NUM_BITS-1, go to DONE.
  - DONE: one cycle.
    - At edge N+LATCH_CYCLES+2*NUM_BITS*HALF_BIT_CYCLES, buttons takes the shift register value and buttons_valid=1.
    - buttons_changed=1 if the new value differs from the previous buttons.
    - busy=0 in the same cycle.
    - Next state: LATCH if pending=1 (clear pending), else IDLE.
- Trigger while busy, or in the DONE cycle: set pending (one deep). Additional triggers are dropped.
- poll_req and auto expiry in the same cycle count as one trigger.
- auto_en deasserted mid-frame: the frame completes normally.
- PRESERN asserted mid-frame: all outputs return to reset values immediately. The partial word is discarded and no valid strobe is issued.
- buttons holds its value between frames. It changes only in DONE.

Decomposition:
- Shared package snes_pad_pkg: state encoding (IDLE, LATCH, SHIFT, DONE), NUM_BITS default, bit-index width.
- One natural sub-module: pad_sync, the 2-flop input synchroniser, reusable for other pad inputs.
- Timers and FSM stay in the top module.

Test Plan (LATCH_CYCLES=8, HALF_BIT_CYCLES=4, POLL_PERIOD_CYCLES=400):
- Pad model drives 16'hFFFF→0 pattern 16'b1111_1111_1111_1110 (bit0 pressed), poll_req pulse at edge 0 -> contWrite high edges 0–7; 16 contCLK low pulses of 4 cycles; buttons=16'h0001, buttons_valid=1 and buttons_changed=1 at edge 136, busy low at edge 136.
- Repeat the same pattern -> buttons_valid=1 with buttons_changed=0.
- Second poll_req at edge 50 of a frame -> pending serviced: contWrite rises at edge 137. Third request at edge 60 dropped: exactly 2 frames.
- auto_en=1, no poll_req -> frames start every 400 cycles; buttons_valid count=3 over 1200 cycles. auto_en=0 -> no further frames.
- PRESERN low at edge 70 mid-SHIFT -> contCLK=1, contWrite=0, busy=0 and buttons retains reset value 0, no valid strobe; a new poll after release completes normally.
- Pattern 16'h5555 (alternating) with contRead changing only on contCLK rising edges -> buttons=16'hAAAA, verifying bit order and sample point.
